// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - key-to-voice allocator for piano_note voices.
// Optional oldest-voice stealing when all voices are busy is enabled by macro VOICE_STEAL_EN.
module voice_allocator #(
    parameter int NUM_KEYS   = 12,
    parameter int NUM_VOICES = 4
) (
    input  logic                    CLK100MHZ,
    input  logic                    CPU_RESETN,
    input  logic [NUM_KEYS-1:0]     key_req,
    input  logic [2:0]              octave,
    output logic [NUM_VOICES-1:0]   voice_key_press,
    output logic [4*NUM_VOICES-1:0] voice_note,
    output logic [3*NUM_VOICES-1:0] voice_octave,
    output logic [3:0]              active_count,
    output logic                    steal_pulse
);

    localparam logic [2:0] AGE_MAX = 3'(NUM_VOICES - 1);

    logic [NUM_KEYS-1:0]     sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [NUM_KEYS-1:0]     pend_press_q, pend_press_d, pend_rel_q, pend_rel_d;
    logic [NUM_VOICES-1:0]   press_q, press_d;
    logic [4*NUM_VOICES-1:0] note_q, note_d;
    logic [3*NUM_VOICES-1:0] oct_q, oct_d, age_q, age_d;
    logic [3:0]              count_q, count_d;
    logic                    steal_q, steal_d;

    always_comb begin
        int rel_k, prs_k, hit_v, free_v, alloc_v;
        logic [NUM_KEYS-1:0] rise, fall;
`ifdef VOICE_STEAL_EN
        int old_v;
        logic [2:0] best_age;
`endif
        sync1_d      = key_req;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        pend_press_d = pend_press_q;
        pend_rel_d   = pend_rel_q;
        press_d      = press_q;
        note_d       = note_q;
        oct_d        = oct_q;
        age_d        = age_q;
        steal_d      = 1'b0;
        rise         = sync2_q & ~prev_q;
        fall         = ~sync2_q & prev_q;
        rel_k        = -1;
        prs_k        = -1;
        hit_v        = -1;
        free_v       = -1;
        alloc_v      = -1;

        // Downward scans leave the lowest matching index in each selector.
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pend_rel_q[k])   rel_k = k;
            if (pend_press_q[k]) prs_k = k;
        end
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (press_q[v] && rel_k >= 0 && note_q[4*v +: 4] == 4'(rel_k)) hit_v = v;
            if (!press_q[v]) free_v = v;
        end
`ifdef VOICE_STEAL_EN
        old_v    = 0;
        best_age = age_q[2:0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_q[3*v +: 3] > best_age) begin
                best_age = age_q[3*v +: 3];
                old_v    = v;
            end
        end
`endif

        if (rel_k >= 0) begin
            for (int k = 0; k < NUM_KEYS; k++)
                if (k == rel_k) pend_rel_d[k] = 1'b0;
            for (int v = 0; v < NUM_VOICES; v++)
                if (v == hit_v) press_d[v] = 1'b0;
        end else if (prs_k >= 0) begin
            for (int k = 0; k < NUM_KEYS; k++)
                if (k == prs_k) pend_press_d[k] = 1'b0;
            if (free_v >= 0) begin
                alloc_v = free_v;
            end
`ifdef VOICE_STEAL_EN
            else begin
                alloc_v = old_v;
                steal_d = 1'b1;
            end
`endif
        end

        if (alloc_v >= 0) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (v == alloc_v) begin
                    press_d[v]         = 1'b1;
                    note_d[4*v +: 4]   = 4'(prs_k);
                    oct_d[3*v +: 3]    = octave;
                    age_d[3*v +: 3]    = 3'd0;
                end else if (press_q[v] && age_q[3*v +: 3] < AGE_MAX) begin
                    age_d[3*v +: 3]    = age_q[3*v +: 3] + 3'd1;
                end
            end
        end

        // New edges override the cleared service bit so no event is lost.
        pend_press_d = (pend_press_d | rise) & ~fall;
        pend_rel_d   = pend_rel_d | fall;

        count_d = 4'd0;
        for (int v = 0; v < NUM_VOICES; v++)
            count_d = count_d + 4'(press_d[v]);
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            pend_press_q <= '0;
            pend_rel_q   <= '0;
            press_q      <= '0;
            note_q       <= '0;
            oct_q        <= '0;
            age_q        <= '0;
            count_q      <= '0;
            steal_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            pend_press_q <= pend_press_d;
            pend_rel_q   <= pend_rel_d;
            press_q      <= press_d;
            note_q       <= note_d;
            oct_q        <= oct_d;
            age_q        <= age_d;
            count_q      <= count_d;
            steal_q      <= steal_d;
        end
    end

    assign voice_key_press = press_q;
    assign voice_note      = note_q;
    assign voice_octave    = oct_q;
    assign active_count    = count_q;
`ifdef VOICE_STEAL_EN
    assign steal_pulse     = steal_q;
`else
    assign steal_pulse     = 1'b0;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - randomized and directed bench for voice_allocator against a reference model.
module tb_voice_allocator;

    localparam int NK = 12;
    localparam int NV = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic [NK-1:0]   key_req;
    logic [2:0]      octave;
    logic [NV-1:0]   voice_key_press;
    logic [4*NV-1:0] voice_note;
    logic [3*NV-1:0] voice_octave;
    logic [3:0]      active_count;
    logic            steal_pulse;

    always #5 clk = ~clk;

    voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV)) dut (
        .CLK100MHZ       (clk),
        .CPU_RESETN      (rstn),
        .key_req         (key_req),
        .octave          (octave),
        .voice_key_press (voice_key_press),
        .voice_note      (voice_note),
        .voice_octave    (voice_octave),
        .active_count    (active_count),
        .steal_pulse     (steal_pulse)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: key levels delayed by a sample history, pending event sets, voice table.
    logic [NK-1:0] hist0, hist1, hist2;
    bit            m_pp[NK];
    bit            m_pr[NK];
    bit            m_on[NV];
    int            m_note[NV];
    int            m_oct[NV];
    int            m_age[NV];
    bit            m_steal;

    task automatic model_reset();
        hist0 = '0; hist1 = '0; hist2 = '0;
        for (int i = 0; i < NK; i++) begin m_pp[i] = 0; m_pr[i] = 0; end
        for (int v = 0; v < NV; v++) begin
            m_on[v] = 0; m_note[v] = 0; m_oct[v] = 0; m_age[v] = 0;
        end
        m_steal = 0;
    endtask

    task automatic model_step();
        int k, v;
        m_steal = 0;
        k = -1;
        for (int i = 0; i < NK && k < 0; i++) if (m_pr[i]) k = i;
        if (k >= 0) begin
            m_pr[k] = 0;
            for (int u = 0; u < NV; u++)
                if (m_on[u] && m_note[u] == k) begin m_on[u] = 0; break; end
        end else begin
            for (int i = 0; i < NK && k < 0; i++) if (m_pp[i]) k = i;
            if (k >= 0) begin
                m_pp[k] = 0;
                v = -1;
                for (int u = 0; u < NV && v < 0; u++) if (!m_on[u]) v = u;
`ifdef VOICE_STEAL_EN
                if (v < 0) begin
                    v = 0;
                    for (int u = 1; u < NV; u++) if (m_age[u] > m_age[v]) v = u;
                    m_steal = 1;
                end
`endif
                if (v >= 0) begin
                    for (int u = 0; u < NV; u++)
                        if (u != v && m_on[u]) m_age[u] = (m_age[u] + 1 > NV - 1) ? NV - 1 : m_age[u] + 1;
                    m_age[v]  = 0;
                    m_on[v]   = 1;
                    m_note[v] = k;
                    m_oct[v]  = int'(octave);
                end
            end
        end
        for (int i = 0; i < NK; i++) begin
            if (hist1[i] && !hist2[i]) m_pp[i] = 1;
            if (!hist1[i] && hist2[i]) begin m_pr[i] = 1; m_pp[i] = 0; end
        end
        hist2 = hist1;
        hist1 = hist0;
        hist0 = key_req;
    endtask

    task automatic check_all();
        logic [NV-1:0]   ev;
        logic [4*NV-1:0] en;
        logic [3*NV-1:0] eo;
        int c;
        c = 0;
        for (int v = 0; v < NV; v++) begin
            ev[v]        = m_on[v];
            en[4*v +: 4] = 4'(m_note[v]);
            eo[3*v +: 3] = 3'(m_oct[v]);
            c += int'(m_on[v]);
        end
        check("voice_key_press", 32'(voice_key_press), 32'(ev));
        check("voice_note",      32'(voice_note),      32'(en));
        check("voice_octave",    32'(voice_octave),    32'(eo));
        check("active_count",    32'(active_count),    32'(c));
        check("steal_pulse",     32'(steal_pulse),     32'(m_steal));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rstn) model_reset();
        else       model_step();
        @(negedge clk);
        check_all();
    endtask

    // Asserted away from a clock edge; outputs must clear without waiting for one.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        cyc();
        cyc();
        rstn = 1'b1;
    endtask

    initial begin
        int idx;
        rstn    = 1'b0;
        key_req = '0;
        octave  = 3'd0;
        model_reset();
        @(negedge clk);
        check_all();
        cyc();
        rstn = 1'b1;

        // Single press: high on the fourth sampling edge, not the third.
        octave = 3'd5;
        repeat (8) cyc();
        key_req[0] = 1'b1;
        repeat (3) cyc();
        check("single_press_early", 32'(voice_key_press[0]), 32'd0);
        cyc();
        check("single_press_vkp", 32'(voice_key_press[0]), 32'd1);
        check("single_press_oct", 32'(voice_octave[2:0]), 32'd5);
        check("single_press_cnt", 32'(active_count), 32'd1);

        // Two simultaneous presses go to voices 0 and 1 in key order.
        key_req = '0;
        do_reset();
        octave = 3'd4;
        key_req = 12'h088;
        repeat (8) cyc();
        check("pair_notes", 32'(voice_note[7:0]), 32'h73);
        check("pair_octaves", 32'(voice_octave[5:0]), 32'o44);

        // Fifth key with all voices busy.
        key_req = 12'h00f;
        do_reset();
        repeat (10) cyc();
        octave = 3'd2;
        key_req[5] = 1'b1;
        repeat (6) cyc();
`ifdef VOICE_STEAL_EN
        check("steal_note", 32'(voice_note[3:0]), 32'd5);
`else
        check("nosteal_note", 32'(voice_note[3:0]), 32'd0);
`endif
        check("full_cnt", 32'(active_count), 32'd4);

        // Release of key 9 held by voice 2 keeps its note.
        key_req = 12'h212;
        do_reset();
        repeat (10) cyc();
        key_req[9] = 1'b0;
        repeat (3) cyc();
        check("release_early", 32'(voice_key_press[2]), 32'd1);
        cyc();
        check("release_vkp", 32'(voice_key_press[2]), 32'd0);
        check("release_note", 32'(voice_note[11:8]), 32'd9);
        check("release_cnt", 32'(active_count), 32'd2);

        // Simultaneous release and press with all voices busy.
        key_req = 12'h01b;
        do_reset();
        repeat (10) cyc();
        key_req = 12'h01d;
        repeat (8) cyc();
        check("swap_note", 32'(voice_note[7:4]), 32'd2);
        check("swap_cnt", 32'(active_count), 32'd4);

        // Reset with voices active and an event in flight.
        key_req = 12'h124;
        do_reset();
        repeat (10) cyc();
        key_req[10] = 1'b1;
        cyc();
        key_req[10] = 1'b0;
        do_reset();
        repeat (10) cyc();
        check("reset_realloc_notes", 32'(voice_note[11:0]), 32'h852);
        check("reset_realloc_vkp", 32'(voice_key_press), 32'h7);

        // Random key toggles, octave changes and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idx     = $urandom_range(0, NK - 1);
                key_req = key_req ^ (12'(1) << idx);
            end
            octave = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) do_reset();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_KEYS, default 12, number of key request inputs, one per semitone (C..B).
REQ-002 Parameter NUM_VOICES, default 4, number of downstream piano_note voices driven; legal range 2..8.
REQ-003 Port CLK100MHZ  input  1  system clock, 100 MHz; all state updates on its rising edge.
REQ-004 Port CPU_RESETN  input  1  reset, asynchronous, active-low.
REQ-005 Port key_req  input  NUM_KEYS  asynchronous level key requests from switches; 1 = key held.
REQ-006 Port octave  input  3  octave applied to a note at allocation time.
REQ-007 Port voice_key_press  output  NUM_VOICES  per-voice key_press for each piano_note instance.
REQ-008 Port voice_note  output  4*NUM_VOICES  per-voice key index 0..NUM_KEYS-1; voice v occupies bits [4v+3:4v].
REQ-009 Port voice_octave  output  3*NUM_VOICES  per-voice latched octave; voice v occupies bits [3v+2:3v].
REQ-010 Port active_count  output  4  number of voices with voice_key_press high.
REQ-011 Port steal_pulse  output  1  one-cycle pulse when an active voice is reassigned.

Function
REQ-012 key_req SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 A rising edge of a synchronized key SHALL set its pending_press bit; a falling edge SHALL set its pending_release bit and clear its pending_press bit.
REQ-014 Exactly one pending event SHALL be serviced per cycle: any release before any press; lowest key index first within each class.
REQ-015 Release service: the voice whose voice_note equals the key and whose voice_key_press is high SHALL drop voice_key_press next cycle; voice_note and voice_octave SHALL hold; if no voice holds the key, the event SHALL be discarded.
REQ-016 Press service: lowest-index voice with voice_key_press low SHALL be loaded with voice_note=key, voice_octave=octave, voice_key_press=1.
REQ-017 Each voice SHALL carry an age counter, 3 bits, saturating at NUM_VOICES-1: on allocation of voice v, age[v]=0 and every other active voice's age SHALL increment (saturating).
REQ-018 Press with no free voice: handled per REQ-027/REQ-028.
REQ-019 An isolated key_req rising edge, with no other events pending, SHALL produce voice_key_press high exactly 4 clock edges after the first edge that samples it; a release SHALL behave the same.
REQ-020 A key pressed while already held by a voice (press after an unserviced release of the same key) SHALL be allocated a new voice only after that release is serviced.
REQ-021 active_count SHALL equal popcount(voice_key_press), registered in the same cycle as voice_key_press.
REQ-022 A change on octave SHALL NOT affect voices that are already allocated.

Reset
REQ-023 While CPU_RESETN is low: voice_key_press=0, voice_note=0, voice_octave=0, active_count=0, steal_pulse=0; synchronizers, pending bits and ages cleared.
REQ-024 A key held through reset release SHALL be seen as a rising edge and allocated per REQ-019.
REQ-025 Reset asserted mid-service SHALL abandon the event with no partial voice update.
REQ-026 No output SHALL change during the first 2 cycles after reset deassertion.

Configuration
REQ-027 Macro VOICE_STEAL_EN defined: a press with no free voice SHALL reassign the voice with maximum age (ties: lowest index), keep voice_key_press high, load voice_note/voice_octave, zero its age, and pulse steal_pulse for one cycle.
REQ-028 Macro VOICE_STEAL_EN undefined: such a press SHALL be discarded, voices unchanged, steal_pulse tied to 0.

Verification
REQ-029 Reset, key_req[0]=1 at cycle 10 -> voice_key_press[0]=1 at cycle 14, voice_note[3:0]=0, voice_octave = octave sampled at allocation, active_count=1.
REQ-030 key_req[3] and key_req[7] rise together, octave=4 -> voice 0 gets note 3, voice 1 gets note 7 one cycle later, both voice_octave=4.
REQ-031 Hold keys 0..3, then raise key 5 (VOICE_STEAL_EN) -> voice 0 (oldest) gets note 5, steal_pulse 1 cycle, active_count stays 4; without macro -> no change, steal_pulse 0.
REQ-032 Voice 2 holds key 9, key 9 released -> voice_key_press[2]=0 after 4 edges, voice_note[11:8]=9 retained, active_count decrements.
REQ-033 Release key 1 and press key 2 in the same cycle with all voices busy -> release serviced first, key 2 takes the freed voice, no steal_pulse.
REQ-034 Assert CPU_RESETN low with 3 voices active and events pending -> all outputs 0 immediately; after deassertion held keys are reallocated to voices 0..2 in key-index order.
